// File: rtl/write_back_queue.sv
// In-order write-back FIFO feeding an enable-loaded register with a registered write strobe.
// Optional same-edge bypass into the output register when empty: define WRITE_BACK_QUEUE_BYPASS_EN.
module write_back_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  input  logic                     out_stall,
  output logic                     out_enable,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [LVL_W-1:0] level_q;
  logic             push;
  logic             pop;
  logic             bypass;
  logic             store;

  assign level    = level_q;
  assign full     = (level_q == LVL_W'(DEPTH));
  assign empty    = (level_q == '0);
  assign in_ready = !full && reset_n;

  assign push = in_valid && in_ready;
  assign pop  = !out_stall && !empty;

`ifdef WRITE_BACK_QUEUE_BYPASS_EN
  // An empty, unstalled queue hands the incoming result straight to the output register.
  assign bypass = push && empty && !out_stall;
`else
  assign bypass = 1'b0;
`endif
  assign store = push && !bypass;

  // Storage stage: data only, no reset
  always_ff @(posedge clock) begin
    if (store) mem[wr_ptr] <= in_data;
  end

  // Control and output register stage; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level_q    <= '0;
      out_enable <= 1'b0;
      out_data   <= '0;
    end else begin
      if (store) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);

      case ({store, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase

      out_enable <= pop || bypass;
      if (pop)         out_data <= mem[rd_ptr];
      else if (bypass) out_data <= in_data;
    end
  end

endmodule
